// File: rtl/muldiv_seq.sv
// Multi-cycle shift-add multiply / restoring divide sequencer driving a shared external adder.
// Define MULDIV_SIGNED_EN to add two's-complement operation (op[1]) through the NEG_* states.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_ra,
  output logic [WIDTH-1:0] add_rb,
  output logic             add_cin,
  output logic             add_en,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | one multiply/divide iteration per cycle
  // DONE   | done pulse, hi/lo valid
  // NEG_A  | magnitude of a (signed build)
  // NEG_B  | magnitude of b (signed build)
  // NEG_LO | negate lo, keep carry (signed build)
  // NEG_HI | negate hi (signed build)
  localparam int CW = $clog2(ITER);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
`ifdef MULDIV_SIGNED_EN
  localparam logic [2:0] S_NEG_A  = 3'd3;
  localparam logic [2:0] S_NEG_B  = 3'd4;
  localparam logic [2:0] S_NEG_LO = 3'd5;
  localparam logic [2:0] S_NEG_HI = 3'd6;
`endif

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, div0_q, div0_d;
  logic [WIDTH-1:0] sh, nxt_acc, nxt_q;
  logic             ge;
`ifdef MULDIV_SIGNED_EN
  logic             sgn_q, sgn_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, carry_q, carry_d;
  logic [WIDTH-1:0] neg_src;
`else
  logic             unused_op1;
  assign unused_op1 = op[1];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    add_ra   = '0;
    add_rb   = '0;
    add_cin  = 1'b0;
    add_en   = 1'b0;
    sh       = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
    ge       = 1'b0;
    nxt_acc  = acc_q;
    nxt_q    = q_q;
`ifdef MULDIV_SIGNED_EN
    sgn_d    = sgn_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    carry_d  = carry_q;
    neg_src  = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          div0_d   = 1'b0;
          is_div_d = op[0];
          if (op[0] && (b == '0)) begin
            hi_d    = a;
            lo_d    = '1;
            div0_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = '0;
            q_d     = op[0] ? a : b;
            m_d     = op[0] ? b : a;
            state_d = S_RUN;
`ifdef MULDIV_SIGNED_EN
            sgn_d    = op[1];
            neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi_d = a[WIDTH-1];
            if (op[1]) state_d = S_NEG_A;
`endif
          end
        end
      end
      S_RUN: begin
        add_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (!is_div_q) begin
          add_ra  = acc_q;
          add_rb  = q_q[0] ? m_q : '0;
          nxt_acc = {add_cout, add_sum[WIDTH-1:1]};
          nxt_q   = {add_sum[0], q_q[WIDTH-1:1]};
        end else begin
          add_ra  = sh;
          add_rb  = ~m_q;
          add_cin = 1'b1;
          ge      = acc_q[WIDTH-1] | add_cout;
          nxt_acc = ge ? add_sum : sh;
          nxt_q   = {q_q[WIDTH-2:0], ge};
        end
        acc_d = nxt_acc;
        q_d   = nxt_q;
        if (cnt_q == CW'(ITER - 1)) begin
          hi_d    = nxt_acc;
          lo_d    = nxt_q;
          state_d = S_DONE;
`ifdef MULDIV_SIGNED_EN
          if (sgn_q) state_d = S_NEG_LO;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef MULDIV_SIGNED_EN
      // a lives in q for divide and in m for multiply; b is in the other register
      S_NEG_A, S_NEG_B: begin
        add_en  = 1'b1;
        neg_src = (is_div_q ^ (state_q == S_NEG_B)) ? q_q : m_q;
        add_ra  = ~neg_src;
        add_cin = 1'b1;
        if (neg_src[WIDTH-1]) begin
          if (is_div_q ^ (state_q == S_NEG_B)) q_d = add_sum;
          else                                  m_d = add_sum;
        end
        state_d = (state_q == S_NEG_A) ? S_NEG_B : S_RUN;
      end
      S_NEG_LO: begin
        add_en  = 1'b1;
        add_ra  = ~lo_q;
        add_cin = 1'b1;
        carry_d = add_cout;
        if (neg_lo_q) lo_d = add_sum;
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        add_en  = 1'b1;
        add_ra  = ~hi_q;
        add_cin = is_div_q ? 1'b1 : carry_q;
        if (is_div_q ? neg_hi_q : neg_lo_q) hi_d = add_sum;
        state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
`ifdef MULDIV_SIGNED_EN
      sgn_q    <= sgn_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      carry_q  <= carry_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle MUL/DIV sequencer for the ALU. It has no adder of its own: it drives the shared 32-bit CLA adder through its operand, carry-in and enable pins every iteration. Shift-add multiply and restoring divide produce the 64-bit result into the HI/LO register pair. The ALU issues one operation at a time and waits on busy/done.

Parameters:
WIDTH, 32, operand width; fixed at 32 to match the adder.
ITER, 32, iterations per operation.

Ports:
clock  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
start  in  1  operation request, sampled only in IDLE
op  in  2  op[0]: 0=mul, 1=div; op[1]: signed (honoured only with MULDIV_SIGNED_EN)
a  in  32  multiplicand / dividend
b  in  32  multiplier / divisor
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse; hi/lo valid
div0  out  1  set with done when a divide had b==0
hi  out  32  product[63:32] / remainder
lo  out  32  product[31:0] / quotient
add_ra  out  32  adder operand A
add_rb  out  32  adder operand B
add_cin  out  1  adder carry-in
add_en  out  1  adder enable
add_sum  in  32  adder sum, combinational, same cycle
add_cout  in  1  adder carry-out

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low (`clear_n`). While clear_n=0: state=IDLE; busy, done and div0=0; hi and lo=0; all internal registers=0; iteration counter=0.
- Adder outputs: add_en=1 only in RUN/NEG states. Otherwise add_ra, add_rb and add_cin are driven 0.
- States: IDLE, RUN, DONE (plus NEG_A, NEG_B, NEG_LO, NEG_HI under the macro).
- IDLE:
  - start=1 latches a, b and op; counter cleared.
  - Divide with b==0 → DONE directly, adder unused. hi=a, lo=32'hFFFFFFFF, div0=1.
  - Otherwise → RUN.
  - start while busy is ignored; no queueing.
- RUN, multiply (acc=0, q=b, m=a at entry):
  - add_ra=acc, add_rb=q[0]?m:0, add_cin=0.
  - Next {acc,q} = {add_cout, add_sum, q} >> 1.
- RUN, divide (r=0, q=a, d=b at entry):
  - sh = {r[30:0], q[31]}.
  - add_ra=sh, add_rb=~d, add_cin=1.
  - ge = r[31] | add_cout.
  - r = ge ? add_sum : sh; q = {q[30:0], ge}.
- RUN exit: counter increments each RUN cycle. After iteration ITER-1 (counter 31) → DONE, with hi=acc/r and lo=q registered on that edge.
- DONE: done=1 for exactly one cycle, then → IDLE. div0 cleared on the next accepted start.
- hi/lo hold until the next DONE or reset.
- Latency, unsigned: done is high during the cycle after the 32nd edge following the sampling edge of start. Divide-by-zero: done on the cycle after the first edge.
- Arithmetic is modulo 2^32 per adder pass. The full 64-bit product is exact with no overflow flag. Quotient and remainder are exact unsigned values.
- Reset mid-operation aborts immediately; no partial result is kept.

Optional Feature:
Macro MULDIV_SIGNED_EN.
- Defined, op[1]=1 — two's-complement operation:
  - NEG_A (1 cycle): if a[31], a = ~a + 1 via the adder (ra=~a, rb=0, cin=1).
  - NEG_B (1 cycle): same for b.
  - RUN as unsigned.
  - NEG_LO (1 cycle): if neg_lo, lo = ~lo + 1; carry saved.
  - NEG_HI (1 cycle): mul: if neg_lo, hi = ~hi + saved carry; div: if neg_hi, hi = ~hi + 1.
  - Sign rules. mul: neg_lo = sign(a)^sign(b). div: neg_lo = sign(a)^sign(b) and neg_hi = sign(a).
  - Signed latency is 36 cycles. -2^31 is handled as magnitude 2^31.
  - Divide-by-zero check happens in IDLE, before NEG_A.
- Not defined: op[1] is ignored; all operations are unsigned; NEG states do not exist.

Test Plan:
- Multiply: a=7, b=6 → done exactly 32 edges after start; hi=0, lo=42; busy high for the 32 RUN cycles plus the DONE cycle.
- Multiply: a=b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001; add_en high only during RUN.
- Divide: 100/7 → lo=14, hi=2. Divide: 32'hFFFFFFFF/1 → lo=32'hFFFFFFFF, hi=0 (exercises the r[31] path).
- Divide: a=5, b=0 → done after 1 edge, div0=1, hi=5, lo=32'hFFFFFFFF. Next start with b=3 clears div0.
- Abort and back-pressure: start a multiply, pulse clear_n low at iteration 10 → busy, hi and lo 0 at once. Re-issue 3*4 → lo=12. A second start while busy has no effect.
- With MULDIV_SIGNED_EN, op[1]=1:
  - -7*3 → hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, latency 36.
  - -7/2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
